// File: rtl/bnn_xnor_acc_pe_if.sv
// Stream, weight-load and forward signals of the XNOR-popcount PE.
// The master side drives windows and loads; the slave side is the PE itself.
interface bnn_xnor_acc_pe_if #(
    parameter int KERNEL_SIZE = 7,
    parameter int ACC_W       = 8,
    parameter int CH_AW       = 2
);
    logic                   w_load;
    logic [CH_AW-1:0]       w_addr;
    logic [KERNEL_SIZE-1:0] w_data;
    logic                   thr_load;
    logic [ACC_W-1:0]       thr_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [KERNEL_SIZE-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_sum;
    logic                   out_bit;
    logic [KERNEL_SIZE-1:0] fwd_data;
    logic                   fwd_valid;

    modport master (
        output w_load, w_addr, w_data, thr_load, thr_data,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_bit, fwd_data, fwd_valid
    );

    modport slave (
        input  w_load, w_addr, w_data, thr_load, thr_data,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_bit, fwd_data, fwd_valid
    );
endinterface

// File: rtl/bnn_xnor_acc_pe.sv
// Multi-channel binary XNOR-popcount PE: accumulates 2*popcount(xnor)-K over
// NUM_CH windows, emits signed sum plus thresholded bit, forwards accepted windows.
module bnn_xnor_acc_pe #(
    parameter int KERNEL_SIZE = 7,
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 8,
    parameter int CH_AW       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bnn_xnor_acc_pe_if.slave   bus
);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    out_state_t state, state_nxt;

    logic [KERNEL_SIZE-1:0]  weight [NUM_CH];
    logic signed [ACC_W-1:0] thr;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] out_sum_q;
    logic                    out_bit_q;
    logic [CH_AW-1:0]        ch_cnt;
    logic [KERNEL_SIZE-1:0]  cur_w;
    logic [KERNEL_SIZE-1:0]  xnor_v;
    logic [ACC_W-1:0]        pop;
    logic [KERNEL_SIZE-1:0]  fwd_data_q;
    logic                    fwd_valid_q;
    logic                    accept;
    logic                    xfer;
    logic                    last_ch;
    logic                    complete;

    assign bus.in_ready = (state == OUT_EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = (state == OUT_FULL) && bus.out_ready;
    assign last_ch      = (ch_cnt == CH_AW'(NUM_CH - 1));
    assign complete     = accept && last_ch;

    // Weight read through a compare-mux so non-power-of-two banks never index past the end.
    always_comb begin
        cur_w = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_cnt == CH_AW'(c)) begin
                cur_w = weight[c];
            end
        end
    end

    always_comb begin
        xnor_v = ~(bus.in_data ^ cur_w);
        pop    = '0;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
            pop = pop + ACC_W'(xnor_v[i]);
        end
    end

    assign term    = $signed((pop << 1) - ACC_W'(KERNEL_SIZE));
    assign acc_sum = acc + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                weight[c] <= '0;
            end
            thr <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (bus.w_load && (bus.w_addr == CH_AW'(c))) begin
                    weight[c] <= bus.w_data;
                end
            end
            if (bus.thr_load) begin
                thr <= $signed(bus.thr_data);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A completion coinciding with a transfer keeps the output full (no bubble).
    always_comb begin
        state_nxt = state;
        case (state)
            OUT_EMPTY: if (complete) state_nxt = OUT_FULL;
            OUT_FULL:  if (xfer && !complete) state_nxt = OUT_EMPTY;
            default:   state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ch_cnt    <= '0;
            out_sum_q <= '0;
            out_bit_q <= 1'b0;
        end else if (accept) begin
            if (last_ch) begin
                out_sum_q <= acc_sum;
                out_bit_q <= (acc_sum >= thr);
                acc       <= '0;
                ch_cnt    <= '0;
            end else begin
                acc    <= acc_sum;
                ch_cnt <= ch_cnt + CH_AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_data_q  <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            fwd_valid_q <= accept;
            if (accept) begin
                fwd_data_q <= bus.in_data;
            end
        end
    end

    assign bus.out_valid = (state == OUT_FULL);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.fwd_data  = fwd_data_q;
    assign bus.fwd_valid = fwd_valid_q;

endmodule

// File: tb/tb_bnn_xnor_acc_pe.sv
// Randomised and directed bench for bnn_xnor_acc_pe against a group-level reference model.
module tb_bnn_xnor_acc_pe;

    localparam int K   = 7;
    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int CAW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_xnor_acc_pe_if #(.KERNEL_SIZE(K), .ACC_W(AW), .CH_AW(CAW)) bus ();
    bnn_xnor_acc_pe_if #(.KERNEL_SIZE(K), .ACC_W(AW), .CH_AW(CAW)) bus3 ();

    bnn_xnor_acc_pe #(.KERNEL_SIZE(K), .NUM_CH(N), .ACC_W(AW), .CH_AW(CAW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    bnn_xnor_acc_pe #(.KERNEL_SIZE(K), .NUM_CH(3), .ACC_W(AW), .CH_AW(CAW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: weight bank, threshold, and the terms of the open group.
    logic [K-1:0] m_w [N];
    int           m_thr;
    int           m_terms [$];
    int           m_sum;
    bit           m_bit;
    bit           m_valid;
    bit           m_fv;
    logic [K-1:0] m_fd;
    int           fwd_cnt;
    int           res_cnt;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dot_term(input logic [K-1:0] x, input logic [K-1:0] w);
        return 2 * $countones(~(x ^ w)) - K;
    endfunction

    task automatic model_reset();
        foreach (m_w[c]) m_w[c] = '0;
        m_thr   = 0;
        m_terms.delete();
        m_sum   = 0;
        m_bit   = 1'b0;
        m_valid = 1'b0;
        m_fv    = 1'b0;
        m_fd    = '0;
    endtask

    task automatic check_outputs();
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("out_sum",   $signed(bus.out_sum), m_sum);
        check("out_bit",   {31'd0, bus.out_bit}, {31'd0, m_bit});
        check("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, m_fv});
        check("fwd_data",  {25'd0, bus.fwd_data}, {25'd0, m_fd});
    endtask

    // Inputs are set at a negedge by the caller; one clock is modelled per call.
    task automatic step();
        bit acc;
        bit xfer;
        int s;
        #1;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
        if (bus.out_valid && bus.out_ready) res_cnt++;
        @(posedge clk);
        acc  = bus.in_valid && (!m_valid || bus.out_ready);
        xfer = m_valid && bus.out_ready;
        if (xfer) m_valid = 1'b0;
        if (acc) begin
            m_terms.push_back(dot_term(bus.in_data, m_w[m_terms.size()]));
            if (m_terms.size() == N) begin
                s = 0;
                foreach (m_terms[i]) s += m_terms[i];
                m_sum   = s;
                m_bit   = (s >= m_thr);
                m_valid = 1'b1;
                m_terms.delete();
            end
            m_fd = bus.in_data;
        end
        m_fv = acc;
        if (bus.w_load && int'(bus.w_addr) < N) m_w[bus.w_addr] = bus.w_data;
        if (bus.thr_load) m_thr = int'($signed(bus.thr_data));
        @(negedge clk);
        if (bus.fwd_valid) fwd_cnt++;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_sum",   $signed(bus.out_sum), 0);
        check("rst_out_bit",   {31'd0, bus.out_bit}, 0);
        check("rst_fwd_valid", {31'd0, bus.fwd_valid}, 0);
        check("rst_fwd_data",  {25'd0, bus.fwd_data}, 0);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_all(input logic [K-1:0] w);
        bus.w_load = 1'b1;
        for (int c = 0; c < N; c++) begin
            bus.w_addr = CAW'(c);
            bus.w_data = w;
            step();
        end
        bus.w_load = 1'b0;
    endtask

    task automatic set_thr(input int t);
        bus.thr_load = 1'b1;
        bus.thr_data = AW'(t);
        step();
        bus.thr_load = 1'b0;
    endtask

    task automatic feed(input logic [K-1:0] x, input int n);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        for (int i = 0; i < n; i++) step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        step();
    endtask

    task automatic tick3();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.w_load = 0; bus.w_addr = '0; bus.w_data = '0;
        bus.thr_load = 0; bus.thr_data = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
        bus3.w_load = 0; bus3.w_addr = '0; bus3.w_data = '0;
        bus3.thr_load = 0; bus3.thr_data = '0;
        bus3.in_valid = 0; bus3.in_data = '0; bus3.out_ready = 1;
        fwd_cnt = 0;
        res_cnt = 0;
        @(negedge clk);
        apply_reset();

        // Weights read as zero after reset: 7'h7F against 0 gives -7 per channel.
        feed(7'h7F, 4);
        check("zero_w_sum", $signed(bus.out_sum), -28);
        drain();

        load_all(7'h7F);
        set_thr(0);
        fwd_cnt = 0;
        feed(7'h7F, 4);
        check("sum28_valid", {31'd0, bus.out_valid}, 1);
        check("sum28", $signed(bus.out_sum), 28);
        check("sum28_bit", {31'd0, bus.out_bit}, 1);
        check("fwd_pulses", fwd_cnt, 4);
        drain();

        feed(7'h00, 4);
        check("sum_m28", $signed(bus.out_sum), -28);
        check("sum_m28_bit", {31'd0, bus.out_bit}, 0);
        drain();
        feed(7'b0000111, 4);
        check("sum_m4", $signed(bus.out_sum), -4);
        check("sum_m4_bit", {31'd0, bus.out_bit}, 0);
        drain();
        set_thr(-4);
        feed(7'b0000111, 4);
        check("thr_m4_bit", {31'd0, bus.out_bit}, 1);
        drain();
        set_thr(0);

        // Backpressure: held result blocks inputs and keeps outputs stable.
        bus.out_ready = 1'b0;
        feed(7'h7F, 4);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_sum", $signed(bus.out_sum), 28);
            check("stall_fwd", {31'd0, bus.fwd_valid}, 0);
        end
        bus.out_ready = 1'b1;
        step();
        check("release_fwd", {31'd0, bus.fwd_valid}, 1);
        feed(7'h7F, 3);
        check("after_stall_sum", $signed(bus.out_sum), 28);
        drain();

        res_cnt = 0;
        feed(7'h7F, 8);
        drain();
        check("stream_results", res_cnt, 2);

        // Reset in the middle of a group discards the partial sum.
        feed(7'h00, 2);
        apply_reset();
        load_all(7'h7F);
        feed(7'h7F, 4);
        check("fresh_after_rst", $signed(bus.out_sum), 28);
        drain();

        // Weight write on the channel being accepted uses the old weight.
        feed(7'h7F, 2);
        bus.w_load = 1'b1; bus.w_addr = 2'd2; bus.w_data = 7'h00;
        feed(7'h7F, 1);
        bus.w_load = 1'b0;
        feed(7'h7F, 1);
        check("old_weight_sum", $signed(bus.out_sum), 28);
        drain();
        feed(7'h7F, 4);
        check("new_weight_sum", $signed(bus.out_sum), 14);
        drain();

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_data   = K'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.w_load    = ($urandom_range(7) == 0);
            bus.w_addr    = CAW'($urandom);
            bus.w_data    = K'($urandom);
            bus.thr_load  = ($urandom_range(15) == 0);
            bus.thr_data  = AW'($urandom_range(56) - 28);
            step();
        end
        bus.w_load = 1'b0;
        bus.thr_load = 1'b0;
        drain();

        // Three-channel instance: a write to channel 3 must be dropped.
        bus3.w_load = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus3.w_addr = CAW'(c);
            bus3.w_data = 7'h7F;
            tick3();
        end
        bus3.w_addr = 2'd3;
        bus3.w_data = 7'h00;
        tick3();
        bus3.w_load = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.in_data  = 7'h7F;
        for (int i = 0; i < 3; i++) tick3();
        bus3.in_valid = 1'b0;
        check("n3_valid", {31'd0, bus3.out_valid}, 1);
        check("n3_sum", $signed(bus3.out_sum), 21);
        check("n3_bit", {31'd0, bus3.out_bit}, 1);
        tick3();
        check("n3_cleared", {31'd0, bus3.out_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
